// File: rtl/serial_deserializer.sv
// serial_deserializer
// Collects a strobed serial bit stream into SIZE-bit words. Each frame begins
// with a frame_start-marked bit. A completed word is handed to a valid/ready
// consumer through a holding register, so the next frame can be received while
// the previous word is still waiting. If a word completes while the previous
// one has not been taken, the new word is dropped and the sticky overrun flag
// is raised.
// Optional build macro: DESER_PARITY_EN adds one even-parity bit per frame,
// a PARITY state and the parity_error output.
module serial_deserializer #(
    parameter int SIZE      = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            serial_in,
    input  logic            serial_en,
    input  logic            frame_start,
    input  logic            data_ready,
    input  logic            overrun_clr,
    output logic [SIZE-1:0] data_out,
    output logic            data_valid,
    output logic            busy,
`ifdef DESER_PARITY_EN
    output logic            parity_error,
`endif
    output logic            overrun
);

    localparam int CW = $clog2(SIZE + 1);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SHIFT  = 2'b01;
`ifdef DESER_PARITY_EN
    localparam logic [1:0] PARITY = 2'b10;
`endif

    // Even parity over a data word (XOR of all bits).
    function automatic logic calc_parity(input logic [SIZE-1:0] word);
        return ^word;
    endfunction

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [SIZE-1:0] sr_r;
    logic [SIZE-1:0] sr_nxt_s;
    logic [SIZE-1:0] shifted_s;
    logic [SIZE-1:0] first_s;
    logic [SIZE-1:0] word_s;
    logic            deliver_s;
    logic            drop_s;
    logic [SIZE-1:0] data_out_r;
    logic            data_valid_r;
    logic            busy_r;
    logic            overrun_r;
`ifdef DESER_PARITY_EN
    logic            perr_s;
    logic            perr_r;
`endif

    // Bit insertion: MSB-first shifts left so the first bit ends at SIZE-1,
    // LSB-first shifts right so the first bit ends at bit 0.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted_s = {sr_r[SIZE-2:0], serial_in};
            first_s   = {{(SIZE-1){1'b0}}, serial_in};
        end else begin
            shifted_s = {serial_in, sr_r[SIZE-1:1]};
            first_s   = {serial_in, {(SIZE-1){1'b0}}};
        end
    end

    // Frame FSM next-state, bit counter, shift register and delivery decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        sr_nxt_s    = sr_r;
        word_s      = sr_r;
        deliver_s   = 1'b0;
`ifdef DESER_PARITY_EN
        perr_s      = 1'b0;
`endif
        if (serial_en) begin
            if (frame_start) begin
                // A marked bit always (re)starts a frame; any partial word is lost.
                sr_nxt_s    = first_s;
                cnt_nxt_s   = CW'(1);
                state_nxt_s = SHIFT;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_nxt_s = IDLE;
                    end
                    SHIFT: begin
                        sr_nxt_s = shifted_s;
                        if (cnt_r == CW'(SIZE - 1)) begin
`ifdef DESER_PARITY_EN
                            cnt_nxt_s   = CW'(SIZE);
                            state_nxt_s = PARITY;
`else
                            word_s      = shifted_s;
                            deliver_s   = 1'b1;
                            cnt_nxt_s   = '0;
                            state_nxt_s = IDLE;
`endif
                        end else begin
                            cnt_nxt_s = cnt_r + CW'(1);
                        end
                    end
`ifdef DESER_PARITY_EN
                    PARITY: begin
                        word_s      = sr_r;
                        perr_s      = calc_parity(sr_r) ^ serial_in;
                        deliver_s   = 1'b1;
                        cnt_nxt_s   = '0;
                        state_nxt_s = IDLE;
                    end
`endif
                    default: begin
                        cnt_nxt_s   = '0;
                        state_nxt_s = IDLE;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
        // A delivery is dropped only if the held word is not being taken now.
        drop_s = deliver_s & data_valid_r & ~data_ready;
    end

    // Receive-side state: FSM, bit count, shift register, busy flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            sr_r    <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            sr_r    <= sr_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Output holding register with valid/ready handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_r       <= 1'b0;
`endif
        end else if (deliver_s && !drop_s) begin
            data_out_r   <= word_s;
            data_valid_r <= 1'b1;
`ifdef DESER_PARITY_EN
            perr_r       <= perr_s;
`endif
        end else if (data_valid_r && data_ready) begin
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= data_valid_r;
        end
    end

    // Sticky overrun flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else if (drop_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;
`ifdef DESER_PARITY_EN
    assign parity_error = perr_r;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (SIZE=8). The main instance is
// MSB-first and is checked through an expected-word queue; a second LSB-first
// instance shares the inputs and is checked directly on bit ordering.
module tb_serial_deserializer;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       serial_en;
    logic       frame_start;
    logic       data_ready;
    logic       overrun_clr;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       overrun;
    logic [7:0] lsb_data_out;
    logic       lsb_data_valid;
    logic       lsb_busy;
    logic       lsb_overrun;
`ifdef DESER_PARITY_EN
    logic       parity_error;
    logic       lsb_parity_error;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    exp_t       sb_q[$];
    exp_t       mon_e;
    logic       prev_valid  = 1'b0;
    logic       prev_accept = 1'b0;
    logic [7:0] tv;

    always #5 clk = ~clk;

    serial_deserializer #(.SIZE(8), .MSB_FIRST(1)) dut (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_en(serial_en),
        .frame_start(frame_start), .data_ready(data_ready), .overrun_clr(overrun_clr),
        .data_out(data_out), .data_valid(data_valid), .busy(busy),
`ifdef DESER_PARITY_EN
        .parity_error(parity_error),
`endif
        .overrun(overrun)
    );

    serial_deserializer #(.SIZE(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .serial_en(serial_en),
        .frame_start(frame_start), .data_ready(data_ready), .overrun_clr(overrun_clr),
        .data_out(lsb_data_out), .data_valid(lsb_data_valid), .busy(lsb_busy),
`ifdef DESER_PARITY_EN
        .parity_error(lsb_parity_error),
`endif
        .overrun(lsb_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic b, input logic fs);
        serial_en   = 1'b1;
        serial_in   = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        serial_en   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends the first n bits of w, most significant first, frame_start on the first.
    task automatic send_seq(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            strobe(w[7-i], (i == 0) ? 1'b1 : 1'b0);
        end
    endtask

    // Full frame, with a correct even-parity bit when parity is built in.
    task automatic send_frame(input logic [7:0] w);
        send_seq(w, 8);
`ifdef DESER_PARITY_EN
        strobe(^w, 1'b0);
`endif
    endtask

    task automatic push(input logic [7:0] w, input logic pe);
        exp_t e;
        e.d  = w;
        e.pe = pe;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a word is presented when data_valid rises or stays high right
    // after an accepting edge; each presentation pops one expected word.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid  <= 1'b0;
            prev_accept <= 1'b0;
        end else begin
            if (data_valid && (!prev_valid || prev_accept)) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", data_out);
                end else begin
                    mon_e = sb_q.pop_front();
`ifdef DESER_PARITY_EN
                    if ({data_out, parity_error} !== {mon_e.d, mon_e.pe}) begin
                        n_err++;
                        $display("FAIL word: got 0x%0h pe=%0b, expected 0x%0h pe=%0b",
                                 data_out, parity_error, mon_e.d, mon_e.pe);
                    end
`else
                    if (data_out !== mon_e.d) begin
                        n_err++;
                        $display("FAIL word: got 0x%0h, expected 0x%0h", data_out, mon_e.d);
                    end
`endif
                end
            end
            prev_valid  <= data_valid;
            prev_accept <= data_valid & data_ready;
        end
    end

    initial begin
        serial_in   = 1'b0;
        serial_en   = 1'b0;
        frame_start = 1'b0;
        data_ready  = 1'b1;
        overrun_clr = 1'b0;
        reset_n     = 1'b0;
        tv          = 8'h00;
        idle(2);
        check("rst_data_out", data_out, 32'h0);
        check("rst_valid", data_valid, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_overrun", overrun, 32'h0);
        reset_n = 1'b1;
        idle(1);

        // Basic frame 1,0,1,0,0,1,0,1 with the consumer ready
        push(8'hA5, 1'b0);
        send_frame(8'hA5);
        idle(2);
        check("a5_valid_cleared", data_valid, 32'h0);
        check("a5_busy_idle", busy, 32'h0);
        check("lsb_a5", lsb_data_out, 32'hA5);

        // Bit order: 1,0,0,0,0,0,0,0 is 0x80 MSB-first, 0x01 LSB-first
        push(8'h80, 1'b0);
        send_frame(8'h80);
        idle(2);
        check("lsb_01", lsb_data_out, 32'h01);

        // Overrun: consumer stalled, second word dropped
        data_ready = 1'b0;
        push(8'h3C, 1'b0);
        send_frame(8'h3C);
        send_frame(8'hC3);
        idle(1);
        check("ovr_hold_data", data_out, 32'h3C);
        check("ovr_hold_valid", data_valid, 32'h1);
        check("ovr_set", overrun, 32'h1);
        overrun_clr = 1'b1;
        idle(1);
        overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 32'h0);
        // Drop coinciding with clear: set wins
        overrun_clr = 1'b1;
        send_frame(8'h11);
        overrun_clr = 1'b0;
        check("ovr_set_wins", overrun, 32'h1);
        check("ovr_still_3c", data_out, 32'h3C);
        overrun_clr = 1'b1;
        idle(1);
        overrun_clr = 1'b0;
        data_ready  = 1'b1;
        idle(2);
        check("ovr_drain_valid", data_valid, 32'h0);
        check("ovr_drain_flag", overrun, 32'h0);

        // Restart after 3 bits, then a full 0x5A
        push(8'h5A, 1'b0);
        send_seq(8'hFF, 3);
        check("partial_busy", busy, 32'h1);
        send_frame(8'h5A);
        idle(2);
        check("restart_data", data_out, 32'h5A);
        check("restart_no_ovr", overrun, 32'h0);

        // Delivery on the same edge that accepts the previous word
        data_ready = 1'b0;
        push(8'h12, 1'b0);
        send_frame(8'h12);
        idle(1);
        push(8'h34, 1'b0);
        tv = 8'h34;
        send_seq(tv, 7);
`ifdef DESER_PARITY_EN
        strobe(tv[0], 1'b0);
        data_ready = 1'b1;
        strobe(^tv, 1'b0);
`else
        data_ready = 1'b1;
        strobe(tv[0], 1'b0);
`endif
        check("same_edge_valid", data_valid, 32'h1);
        check("same_edge_data", data_out, 32'h34);
        check("same_edge_no_ovr", overrun, 32'h0);
        idle(2);
        check("same_edge_drained", data_valid, 32'h0);

`ifdef DESER_PARITY_EN
        // Parity: correct bit, then a wrong bit
        push(8'hA5, 1'b0);
        send_seq(8'hA5, 8);
        check("parity_state_busy", busy, 32'h1);
        strobe(1'b0, 1'b0);
        idle(2);
        check("parity_ok", parity_error, 32'h0);
        push(8'hA5, 1'b1);
        send_seq(8'hA5, 8);
        strobe(1'b1, 1'b0);
        idle(2);
        check("parity_bad", parity_error, 32'h1);
`endif

        // Reset in the middle of a frame
        send_seq(8'hE0, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_data", data_out, 32'h0);
        check("midrst_valid", data_valid, 32'h0);
        check("midrst_busy", busy, 32'h0);
        check("midrst_overrun", overrun, 32'h0);
`ifdef DESER_PARITY_EN
        check("midrst_perr", parity_error, 32'h0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        // Bits without frame_start after reset are ignored
        for (int i = 0; i < 9; i++) begin
            strobe(1'b1, 1'b0);
        end
        idle(1);
        check("nofs_busy", busy, 32'h0);
        check("nofs_valid", data_valid, 32'h0);
        push(8'h77, 1'b0);
        send_frame(8'h77);
        idle(2);
        check("post_rst_data", data_out, 32'h77);

        idle(3);
        check("scoreboard_empty", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
